// File: rtl/dmem_unit.sv
// dmem_unit: clocked data memory for the memory stage.
// One request/response transaction at a time. The access is performed after
// WAIT_CYCLES wait states. It supports byte/half/word/double accesses with
// sign or zero extension, and every accepted request returns one response.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> a misaligned access returns rsp_err = 1
//   undefined -> a misaligned access is aligned down to the access size
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_write                1 = store, 0 = load
//   req_size                 0 byte, 1 half, 2 word, 3 double
//   req_signed               sign-extend load result
//   req_addr [ADDR_W]        byte address
//   req_wdata [DATA_W]       right-aligned store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata [DATA_W]       load result (0 for stores and errors)
//   rsp_err                  access rejected
module dmem_unit #(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SH_W  = OFF_W + 3;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                w_accept, w_access;

   logic                r_req_ready, r_rsp_valid, r_rsp_err;
   logic [DATA_W-1:0]   r_rsp_rdata;

   logic                r_write, r_signed;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;

   // Storage holds each word XOR its power-up image (word i = i*100),
   // so an all-zero array reads back as the preloaded contents.
   logic [DATA_W-1:0]   r_mem_x [DEPTH];

   logic [ADDR_W-1:0]   w_word_idx;
   logic [IDX_W-1:0]    w_idx;
   logic [3:0]          w_sb;
   logic [OFF_W-1:0]    w_off, w_sb_m1, w_aoff;
   logic [SH_W-1:0]     w_shift;
   logic                w_trap, w_err, w_sign;
   logic [DATA_W-1:0]   w_base, w_word, w_lane, w_mask, w_load, w_store;

   // State and wait counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state, accept and access strobes
   always_comb begin : fsm_next
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid && r_req_ready) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_access    = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Address decode, error detection, load extraction and store merge
   always_comb begin : access_path
      w_word_idx = r_addr >> OFF_W;
      w_idx      = r_addr[OFF_W +: IDX_W];
      w_sb       = 4'd1 << r_size;
      w_off      = r_addr[OFF_W-1:0];
      w_sb_m1    = OFF_W'(w_sb - 4'd1);
      w_aoff     = w_off & ~w_sb_m1;
      w_shift    = {w_aoff, 3'b000};
`ifdef DMEM_MISALIGN_TRAP_EN
      w_trap     = (w_off & w_sb_m1) != '0;
`else
      w_trap     = 1'b0;
`endif
      w_err      = (w_word_idx >= ADDR_W'(DEPTH)) || (w_sb > 4'(BYTES)) || w_trap;
      w_base     = DATA_W'(32'(w_idx) * 32'd100);
      w_word     = r_mem_x[w_idx] ^ w_base;
      w_lane     = w_word >> w_shift;

      // Full-width accesses keep an all-ones mask, so no extension applies
      w_mask = '1;
      w_sign = 1'b0;
      case (r_size)
         2'd0: begin w_mask = DATA_W'(8'hFF);         w_sign = w_lane[7];  end
         2'd1: begin w_mask = DATA_W'(16'hFFFF);      w_sign = w_lane[15]; end
         2'd2: begin w_mask = DATA_W'(32'hFFFF_FFFF); w_sign = w_lane[31]; end
         default: ;
      endcase

      w_load  = (w_lane & w_mask) | ((r_signed && w_sign) ? ~w_mask : '0);
      w_store = (w_word & ~(w_mask << w_shift)) | ((r_wdata & w_mask) << w_shift);
   end

   // Request capture and registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_write     <= 1'b0;
         r_size      <= '0;
         r_signed    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_rsp_valid <= (w_state_nxt == S_RESP);
         if (w_accept) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
         end
         if (w_access) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_write) ? '0 : w_load;
         end
      end
   end

   // Memory write; reset discards a store whose access edge coincides with it
   always_ff @(posedge clk) begin
      if (!rst && w_access && r_write && !w_err) begin
         r_mem_x[w_idx] <= w_store ^ w_base;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: directed scenarios plus randomized
// traffic against a byte-level reference model of the memory.
module tb_dmem_unit;

   localparam int unsigned WAIT1 = 1;
   localparam int unsigned WAIT3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (WAIT_CYCLES = 1)
   logic        rst = 1'b1, req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic        rsp_ready = 1'b1;
   logic [1:0]  req_size = '0;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [63:0] rsp_rdata;

   // Second instance (WAIT_CYCLES = 3) for the mid-operation reset case
   logic        b_rst = 1'b1, b_req_valid = 1'b0, b_req_write = 1'b0, b_req_signed = 1'b0;
   logic        b_rsp_ready = 1'b1;
   logic [1:0]  b_req_size = '0;
   logic [63:0] b_req_addr = '0, b_req_wdata = '0;
   logic        b_req_ready, b_rsp_valid, b_rsp_err;
   logic [63:0] b_rsp_rdata;

   int checks = 0;
   int errors = 0;
   time acc_time;

   logic [63:0] mem_model [32];

   dmem_unit #(.DATA_W(64), .DEPTH(32), .ADDR_W(64), .WAIT_CYCLES(WAIT1)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   dmem_unit #(.DATA_W(64), .DEPTH(32), .ADDR_W(64), .WAIT_CYCLES(WAIT3)) u_dut3 (
      .clk(clk), .rst(b_rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
      .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_err(b_rsp_err)
   );

   // Reference model: byte-by-byte little-endian memory of 32 eight-byte words
   function automatic void model_access(input bit wr, input bit [1:0] sz, input bit sg,
                                        input logic [63:0] addr, input logic [63:0] wd,
                                        output logic [63:0] rd, output bit er);
      longint unsigned a;
      int nb;
      int idx;
      int off;
      a  = addr;
      nb = 1 << sz;
      rd = '0;
      er = 1'b0;
      if (a / 8 >= 32) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (a % nb != 0) er = 1'b1;
`else
      a = a - (a % nb);
`endif
      if (!er) begin
         idx = int'(a / 8);
         off = int'(a % 8);
         for (int b = 0; b < nb; b++) begin
            if (wr) mem_model[idx][(off + b) * 8 +: 8] = wd[b * 8 +: 8];
            else    rd[b * 8 +: 8] = mem_model[idx][(off + b) * 8 +: 8];
         end
         if (!wr && sg && nb < 8 && rd[nb * 8 - 1]) begin
            for (int b = nb; b < 8; b++) rd[b * 8 +: 8] = 8'hFF;
         end
      end
   endfunction

   // One full transaction on the main instance with rsp_ready high.
   // lat = clock edges from accept until rsp_valid is seen, -1 on timeout.
   task automatic do_txn(input bit wr, input bit [1:0] sz, input bit sg,
                         input logic [63:0] a, input logic [63:0] wd,
                         output logic [63:0] rd, output bit er, output int lat);
      int guard;
      lat = -1;
      @(negedge clk);
      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      acc_time = $time;
      #1 req_valid = 1'b0;
      guard = 0;
      while (rsp_valid !== 1'b1 && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (rsp_valid === 1'b1) lat = guard;
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; b_rst = 1'b1;
      req_valid = 1'b1; req_addr = 64'h50; req_size = 2'd3;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
      @(negedge clk);
      rst = 1'b0; b_rst = 1'b0; req_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_nothing_captured rsp_valid got %b want 0", rsp_valid); end
   endtask

   task automatic test_load_store();
      logic [63:0] rd, mrd;
      bit er, mer;
      int lat;
      model_access(1'b0, 2'd3, 1'b0, 64'h50, '0, mrd, mer);
      do_txn(1'b0, 2'd3, 1'b0, 64'h50, '0, rd, er, lat);
      checks++; if (rd !== 64'd1000) begin errors++; $display("FAIL dbl_load_0x50 got %0d want 1000", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL dbl_load_0x50_err got %b want 0", er); end
      checks++; if (lat != 2) begin errors++; $display("FAIL dbl_load_latency got %0d want 2", lat); end

      model_access(1'b1, 2'd0, 1'b0, 64'h0B, 64'hFF, mrd, mer);
      do_txn(1'b1, 2'd0, 1'b0, 64'h0B, 64'hFF, rd, er, lat);
      checks++; if (rd !== 64'd0 || er !== 1'b0) begin errors++; $display("FAIL store_byte_rsp got rd=%h err=%b want 0/0", rd, er); end

      do_txn(1'b0, 2'd0, 1'b1, 64'h0B, '0, rd, er, lat);
      checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL signed_byte_load got %h want ffffffffffffffff", rd); end

      do_txn(1'b0, 2'd3, 1'b0, 64'h08, '0, rd, er, lat);
      checks++; if (rd !== 64'h0000_0000_FF00_0064) begin errors++; $display("FAIL dbl_load_0x08 got %h want 00000000ff000064", rd); end

      do_txn(1'b0, 2'd1, 1'b0, 64'h101, '0, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL half_load_0x101 got rd=%h err=%b want 0/1", rd, er); end

      do_txn(1'b1, 2'd3, 1'b0, 64'h100, 64'hDEAD_BEEF, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL dbl_store_0x100_err got %b want 1", er); end
      do_txn(1'b0, 2'd3, 1'b0, 64'h00, '0, rd, er, lat);
      checks++; if (rd !== 64'd0) begin errors++; $display("FAIL oob_store_alias_word0 got %h want 0", rd); end
      do_txn(1'b0, 2'd3, 1'b0, 64'hF8, '0, rd, er, lat);
      checks++; if (rd !== 64'd3100) begin errors++; $display("FAIL oob_store_word31 got %0d want 3100", rd); end

      do_txn(1'b0, 2'd2, 1'b0, 64'h12, '0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
      checks++; if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL misaligned_word_0x12 got rd=%h err=%b want 0/1", rd, er); end
`else
      checks++; if (er !== 1'b0 || rd !== 64'd200) begin errors++; $display("FAIL misaligned_word_0x12 got rd=%0d err=%b want 200/0", rd, er); end
`endif
   endtask

   task automatic test_stall();
      int guard;
      @(negedge clk);
      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'h20;
      @(posedge clk);
      #1 req_valid = 1'b0;
      guard = 0;
      while (rsp_valid !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_valid_timeout got %b want 1", rsp_valid); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 64'd400 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got v=%b rd=%0d err=%b rdy=%b want 1/400/0/0",
                     i, rsp_valid, rsp_rdata, rsp_err, req_ready);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got rdy=%b v=%b want 1/0", req_ready, rsp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] rd;
      bit er;
      int lat;
      time t0;
      do_txn(1'b0, 2'd3, 1'b0, 64'h28, '0, rd, er, lat);
      t0 = acc_time;
      checks++; if (rd !== 64'd500) begin errors++; $display("FAIL b2b_first got %0d want 500", rd); end
      do_txn(1'b0, 2'd3, 1'b0, 64'h30, '0, rd, er, lat);
      checks++; if (rd !== 64'd600) begin errors++; $display("FAIL b2b_second got %0d want 600", rd); end
      checks++; if (acc_time - t0 != (WAIT1 + 3) * 10) begin errors++; $display("FAIL b2b_spacing got %0t want %0d", acc_time - t0, (WAIT1 + 3) * 10); end
   endtask

   task automatic test_random();
      logic [63:0] rd, mrd, a, wd;
      bit er, mer, wr, sg;
      bit [1:0] sz;
      int lat;
      for (int n = 0; n < 300; n++) begin
         wr = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a  = 64'($urandom_range(0, 32'h10F));
         wd = {$urandom, $urandom};
         model_access(wr, sz, sg, a, wd, mrd, mer);
         do_txn(wr, sz, sg, a, wd, rd, er, lat);
         checks++;
         if (rd !== mrd || er !== mer || lat != WAIT1 + 1) begin
            errors++;
            $display("FAIL random #%0d wr=%b sz=%0d sg=%b a=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                     n, wr, sz, sg, a, rd, er, lat, mrd, mer, WAIT1 + 1);
         end
      end
   endtask

   task automatic test_wait3_reset();
      int guard;
      @(negedge clk);
      guard = 0;
      while (b_req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      b_req_valid = 1'b1; b_req_write = 1'b1; b_req_size = 2'd3; b_req_signed = 1'b0;
      b_req_addr = 64'h18; b_req_wdata = 64'h1234;
      @(posedge clk);
      #1 b_req_valid = 1'b0;
      @(posedge clk);
      #1 b_rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b0) begin errors++; $display("FAIL w3_reset_drop got v=%b rdy=%b want 0/0", b_rsp_valid, b_req_ready); end
      @(negedge clk);
      b_rst = 1'b0;
      guard = 0;
      while (b_req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 64'h18;
      @(posedge clk);
      #1 b_req_valid = 1'b0;
      guard = 0;
      while (b_rsp_valid !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
      checks++; if (guard != WAIT3 + 1) begin errors++; $display("FAIL w3_latency got %0d want %0d", guard, WAIT3 + 1); end
      checks++; if (b_rsp_rdata !== 64'd300 || b_rsp_err !== 1'b0) begin errors++; $display("FAIL w3_store_discarded got rd=%0d err=%b want 300/0", b_rsp_rdata, b_rsp_err); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem_model[i] = 64'(i * 100);
      test_reset();
      test_load_store();
      test_stall();
      test_back_to_back();
      test_random();
      test_wait3_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Clocked, parametrised data memory for the CPU's memory stage. It replaces the combinational word-only store with a request/response handshake, configurable wait states and byte/half/word/double accesses with sign or zero extension. Each accepted request returns exactly one response, including writes and errored accesses. The load/store unit sits upstream; load data returns to the write-back path.

## Interface
- DATA_W, 64 — data width in bits; legal values 32 or 64.
- DEPTH, 32 — number of DATA_W-bit words.
- ADDR_W, 64 — byte-address width.
- WAIT_CYCLES, 1 — extra wait states per access; legal range 0..15.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_signed  in  1  load result is sign-extended when 1, zero-extended when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
- rsp_err  out  1  access was rejected.

## Operation
- States: IDLE, WAIT, RESP.
- req_ready is 1 only in IDLE.
- Accept (req_valid && req_ready) captures write, size, signed, addr and wdata, loads the counter with WAIT_CYCLES and moves to WAIT.
- WAIT:
  - counter ≠ 0: decrement.
  - counter = 0: perform the access on this edge, register rdata/err, move to RESP.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready is seen, then the unit returns to IDLE.
- Addressing: word index = addr >> log2(DATA_W/8); lane offset = low log2(DATA_W/8) bits. Lanes are little-endian.
- Stores write only the addressed bytes; other bytes are unchanged.
- Loads return the addressed bytes, right-aligned and extended per req_signed. A double load, or a word load when DATA_W = 32, is never extended.
- Errors (no write occurs, rdata = 0, err = 1):
  - word index ≥ DEPTH;
  - size bytes > DATA_W/8 (size 3 when DATA_W = 32);
  - misaligned access when the trap feature is enabled (see Configuration).
- Contents: word i = i*100 at time zero. rst does not alter memory contents.

## Timing
- Reset values: req_ready = 0 during rst, 1 on the cycle after rst deasserts; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; state = IDLE; counter = 0.
- Latency: accept at edge N → rsp_valid high after edge N+WAIT_CYCLES+1.
- Store data is visible to any later load.
- Minimum cycle: one request per WAIT_CYCLES+3 clocks (rsp_ready held high).
- rsp_ready high while rsp_valid is low is ignored.
- req_valid while not ready: the request is not captured; the requester must hold it.
- rst mid-operation (WAIT or RESP): return to IDLE and drop the response. A store whose access edge has not yet occurred is discarded. A store already performed remains in memory.
- rst and accept on the same edge: rst wins and nothing is captured.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: addr not a multiple of the size in bytes → rsp_err = 1, no write, rdata = 0.
- DMEM_MISALIGN_TRAP_EN undefined: the low address bits below the access size are cleared (access aligned down). rsp_err is never set for misalignment.

## Test plan
All scenarios use DATA_W=64, DEPTH=32, WAIT_CYCLES=1 unless stated otherwise.
- Reset then double load at addr 0x50 (word 10) → rsp_valid 2 cycles after accept, rdata = 1000, err = 0.
- Store byte 0xFF at addr 0x0B, then signed byte load at 0x0B → 0xFFFF_FFFF_FFFF_FFFF. Unsigned double load at 0x08 → 0x0000_0000_FF00_0064 (word 1 was 100).
- Half load at 0x101 (word 32):
  - with DMEM_MISALIGN_TRAP_EN defined → err = 1, rdata = 0.
  - a double store at 0x100 → err = 1, and memory is unchanged.
- Misaligned word load at 0x12 with DMEM_MISALIGN_TRAP_EN defined → err = 1. Undefined → reads 0x10, rdata = 200.
- Hold rsp_ready low for 5 cycles → rsp_valid, rdata and err stay stable and req_ready stays 0. Raise rsp_ready → req_ready = 1 on the next cycle.
- WAIT_CYCLES=3: store double 0x1234 at 0x18, assert rst two cycles after accept → memory word 3 is still 300. A follow-up load at 0x18 returns 300 after 4 cycles.
